io_sw_debounce: RTL and testbench

//  Input-side peripheral front end for the pipelined RV32I core. It synchronises the raw board

---
 rtl/io_pkg.sv | 18 +
 rtl/sw_debounce_bit.sv | 110 +++++++++++
 rtl/io_sw_debounce.sv | 77 +++++++
 tb/tb_io_sw_debounce.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the board I/O front-end blocks.
// Holds the word width, debounce defaults and the per-bit debounce state encoding.
package io_pkg;

  localparam int unsigned IO_WORD_W           = 32;
  localparam int unsigned SW_NUM_DEF          = 18;
  localparam int unsigned SW_SYNC_STAGES_DEF  = 2;
  localparam int unsigned SW_DEBOUNCE_CYC_DEF = 500_000;
  localparam int unsigned SW_CNT_W_DEF        = 20;

  typedef enum logic [1:0] {
    ST_LO,
    WAIT_HI,
    ST_HI,
    WAIT_LO
  } sw_db_state_e;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: synchroniser, debounce FSM and stability counter.
// A level is accepted only after DEBOUNCE_CYC consecutive synchronised samples agree.
module sw_debounce_bit
  import io_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = SW_SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYC = SW_DEBOUNCE_CYC_DEF,
  parameter int unsigned CNT_W        = SW_CNT_W_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sw_raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy_c
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  sw_db_state_e           state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_d, rise_d, fall_d;

  // Plain shift chain, nothing between stages.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_sw_raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_LO;
      cnt_q   <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level   <= level_d;
      rise    <= rise_d;
      fall    <= fall_d;
    end
  end

  // Counter is cleared on every state change, so it never needs to wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Next-state view so the top can register stability in step with the FSM.
  assign busy_c = (state_d == WAIT_HI) || (state_d == WAIT_LO);

endmodule

// File: rtl/io_sw_debounce.sv
// Switch front end: per-bit debounce, zero-extended level word, sticky edge events
// and a registered all-stable flag for the core's I/O map.
module io_sw_debounce
  import io_pkg::*;
#(
  parameter int unsigned NUM_SW       = SW_NUM_DEF,
  parameter int unsigned SYNC_STAGES  = SW_SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYC = SW_DEBOUNCE_CYC_DEF,
  parameter int unsigned CNT_W        = SW_CNT_W_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NUM_SW-1:0]    i_sw_raw,
  input  logic                 i_evt_clr,
  output logic [IO_WORD_W-1:0] o_io_sw,
  output logic [NUM_SW-1:0]    o_sw_rise,
  output logic [NUM_SW-1:0]    o_sw_fall,
  output logic [IO_WORD_W-1:0] o_sw_evt,
  output logic                 o_sw_stable
);

  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  if (NUM_SW < 1 || NUM_SW > IO_WORD_W) begin : g_bad_num_sw
    $fatal(1, "io_sw_debounce: NUM_SW out of range 1..32");
  end
  if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
    $fatal(1, "io_sw_debounce: DEBOUNCE_CYC must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $fatal(1, "io_sw_debounce: SYNC_STAGES must be >= 2");
  end
  if (CNT_W < 1 || CNT_W > 63 || (64'(DEBOUNCE_CYC) - 64'd1) > CNT_MAX) begin : g_bad_cnt_w
    $fatal(1, "io_sw_debounce: CNT_W cannot hold DEBOUNCE_CYC-1");
  end

  logic [NUM_SW-1:0] level;
  logic [NUM_SW-1:0] rise;
  logic [NUM_SW-1:0] fall;
  logic [NUM_SW-1:0] busy_c;
  logic [NUM_SW-1:0] evt_q;
  logic              stable_q;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_bit
    sw_debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .CNT_W       (CNT_W)
    ) u_bit (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_sw_raw(i_sw_raw[g]),
      .level   (level[g]),
      .rise    (rise[g]),
      .fall    (fall[g]),
      .busy_c  (busy_c[g])
    );
  end

  // A new edge in the same cycle as a clear wins, so no event is dropped.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      evt_q    <= '0;
      stable_q <= 1'b1;
    end else begin
      evt_q    <= (evt_q & ~{NUM_SW{i_evt_clr}}) | rise | fall;
      stable_q <= ~|busy_c;
    end
  end

  assign o_io_sw     = IO_WORD_W'(level);
  assign o_sw_rise   = rise;
  assign o_sw_fall   = fall;
  assign o_sw_evt    = IO_WORD_W'(evt_q);
  assign o_sw_stable = stable_q;

endmodule

// File: tb/tb_io_sw_debounce.sv
// Bench for io_sw_debounce: expected pulse events are queued when a switch change is
// driven and matched against the DUT's rise/fall pulses as they appear.
module tb_io_sw_debounce;

  localparam int unsigned NSW  = 4;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;
  localparam int          LAT  = SYNC + DEB;

  typedef struct {
    int          cyc;
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic [31:0] io;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sw_raw;
  logic        evt_clr;
  logic [31:0] io_sw;
  logic [3:0]  sw_rise;
  logic [3:0]  sw_fall;
  logic [31:0] sw_evt;
  logic        sw_stable;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc   = 0;
  exp_t        sb[$];
  logic [3:0]  raw;
  logic [31:0] prev_io = 32'h0;

  io_sw_debounce #(
    .NUM_SW      (NSW),
    .SYNC_STAGES (SYNC),
    .DEBOUNCE_CYC(DEB),
    .CNT_W       (3)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_sw_raw   (sw_raw),
    .i_evt_clr  (evt_clr),
    .o_io_sw    (io_sw),
    .o_sw_rise  (sw_rise),
    .o_sw_fall  (sw_fall),
    .o_sw_evt   (sw_evt),
    .o_sw_stable(sw_stable)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pulse monitor: every rise/fall pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && io_sw !== prev_io)
      check("io_change_with_pulse", 32'((sw_rise | sw_fall) != 4'b0), 32'd1);
    prev_io = io_sw;
    if (sb.size() != 0 && sb[0].cyc < cyc) begin
      check("missed_pulse", 32'(cyc), 32'(sb[0].cyc));
      void'(sb.pop_front());
    end
    if ((sw_rise | sw_fall) != 4'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {24'h0, sw_rise, sw_fall}, 32'h0);
      end else begin
        e = sb.pop_front();
        check("pulse_cyc", 32'(cyc), 32'(e.cyc));
        check("pulse_rise", 32'(sw_rise), 32'(e.rise));
        check("pulse_fall", 32'(sw_fall), 32'(e.fall));
        check("pulse_io", io_sw, e.io);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a clean level change and queue the pulse it must produce.
  task automatic set_raw(input logic [3:0] v);
    exp_t e;
    if (v != raw) begin
      e.cyc  = cyc + 1 + LAT;
      e.rise = v & ~raw;
      e.fall = ~v & raw;
      e.io   = 32'(v);
      sb.push_back(e);
    end
    raw    = v;
    sw_raw = v;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic pulse_clr();
    evt_clr = 1'b1;
    tick(1);
    evt_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   m;
    int   t;
    int   last;

    rst     = 1'b1;
    raw     = 4'hF;
    sw_raw  = 4'hF;
    evt_clr = 1'b0;

    // Reset with all switches held high.
    tick(3);
    check("rst_io", io_sw, 32'h0);
    check("rst_rise", 32'(sw_rise), 32'h0);
    check("rst_fall", 32'(sw_fall), 32'h0);
    check("rst_evt", sw_evt, 32'h0);
    check("rst_stable", 32'(sw_stable), 32'd1);
    rst   = 1'b0;
    e.cyc = cyc + 1 + LAT; e.rise = 4'hF; e.fall = 4'h0; e.io = 32'hF;
    sb.push_back(e);
    tick(4);
    check("rel_stable_wait", 32'(sw_stable), 32'd0);
    drain();
    check("rel_io", io_sw, 32'h0000_000F);
    set_raw(4'h0);
    drain();
    tick(1);
    check("all_low_stable", 32'(sw_stable), 32'd1);
    pulse_clr();
    check("evt_cleared", sw_evt, 32'h0);

    // Clean edge on bit0 and the stable window around it.
    set_raw(4'b0001);
    tick(2);
    check("t2_stable_pre", 32'(sw_stable), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("t2_stable_wait", 32'(sw_stable), 32'd0);
    end
    tick(1);
    check("t2_stable_post", 32'(sw_stable), 32'd1);
    tick(1);
    check("t2_io", io_sw, 32'h1);
    check("t2_evt", sw_evt, 32'h1);

    // Three-cycle glitch on bit1 is rejected.
    pulse_clr();
    check("t3_evt_clr", sw_evt, 32'h0);
    sw_raw = raw | 4'b0010;
    tick(3);
    sw_raw = raw;
    tick(1);
    check("t3_stable_wait", 32'(sw_stable), 32'd0);
    tick(3);
    check("t3_stable_back", 32'(sw_stable), 32'd1);
    tick(10);
    check("t3_io", io_sw, 32'h1);
    check("t3_evt", sw_evt, 32'h0);

    // Bounce on bit2: 1,0,1,0,1 then high.
    last = 0;
    for (int i = 0; i < 5; i++) begin
      sw_raw = raw | ((i % 2 == 0) ? 4'b0100 : 4'b0000);
      if (i % 2 == 0) last = cyc;
      tick(1);
    end
    raw    = raw | 4'b0100;
    sw_raw = raw;
    e.cyc = last + 1 + LAT; e.rise = 4'b0100; e.fall = 4'h0; e.io = 32'h5;
    sb.push_back(e);
    drain();
    check("t4_io", io_sw, 32'h5);

    // Sticky-clear race: bit3 fall coincides with the clear.
    set_raw(4'b1101);
    drain();
    tick(2);
    pulse_clr();
    check("t5_evt_zero", sw_evt, 32'h0);
    set_raw(4'b1100);
    drain();
    tick(2);
    check("t5_evt_pre", sw_evt, 32'h1);
    set_raw(4'b0100);
    t = sb[$].cyc;
    while (cyc < t) tick(1);
    evt_clr = 1'b1;
    tick(1);
    evt_clr = 1'b0;
    check("t5_evt_race", sw_evt, 32'h8);
    drain();

    // Reset two cycles into WAIT_HI on bit0.
    set_raw(4'b0000);
    drain();
    sw_raw = 4'b0001;
    m = cyc;
    tick(3);
    check("t6_wait", 32'(sw_stable), 32'd0);
    tick(1);
    rst = 1'b1;
    tick(1);
    check("t6_rst_io", io_sw, 32'h0);
    check("t6_rst_stable", 32'(sw_stable), 32'd1);
    check("t6_rst_evt", sw_evt, 32'h0);
    check("t6_rst_rise", 32'(sw_rise), 32'h0);
    tick(1);
    rst = 1'b0;
    raw = 4'b0001;
    e.cyc = cyc + 1 + LAT; e.rise = 4'b0001; e.fall = 4'h0; e.io = 32'h1;
    sb.push_back(e);
    drain();
    check("t6_io", io_sw, 32'h1);
    check("t6_start", 32'(cyc > m), 32'd1);

    tick(5);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
